// File: rtl/irq_agg_pkg.sv
// Shared definitions for the APB interrupt aggregator: register indices,
// CLAIM layout and a lowest-set-bit helper.
package irq_agg_pkg;

  typedef enum logic [2:0] {
    RAW   = 3'd0,
    PEND  = 3'd1,
    EN    = 3'd2,
    MODE  = 3'd3,
    CLAIM = 3'd4,
    FORCE = 3'd5,
    RSVD6 = 3'd6,
    RSVD7 = 3'd7
  } reg_idx_e;

  localparam int unsigned CLAIM_VALID_BIT = 31;
  localparam int unsigned CLAIM_IDX_W     = 5;

  // Scans from the top down so the last hit is the lowest index.
  function automatic logic [CLAIM_IDX_W-1:0] lowest_set(input logic [31:0] vec);
    logic [CLAIM_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 32; i > 0; i--) begin
      if (vec[i-1]) idx = CLAIM_IDX_W'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source conditioning: polarity normalisation, synchronizer chain and
// one-cycle history for rising-edge detection.
module irq_sync_edge
  import irq_agg_pkg::*;
#(
  parameter int unsigned IRQ_ACTIVE_HIGH = 1,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  output logic level,
  output logic rise
);

  logic act;
  logic s;
  logic prev_q, prev_d;

  assign act = (IRQ_ACTIVE_HIGH != 0) ? src : ~src;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = act;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q, sync_d;

      always_comb begin
        sync_d    = sync_q;
        sync_d[0] = act;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_comb begin
    prev_d = s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign level = s;
  assign rise  = s & ~prev_q;

endmodule

// File: rtl/apb_irq_aggregator.sv
// APB3 interrupt aggregator: latches conditioned sources as pending, gates them
// by enable and drives one registered IRQ; software services via PENDING/CLAIM.
module apb_irq_aggregator
  import irq_agg_pkg::*;
#(
  parameter int unsigned NUM_IRQ         = 8,
  parameter int unsigned IRQ_ACTIVE_HIGH = 1,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [4:2]         PADDR,
  input  logic [31:0]        PWDATA,
  output logic [31:0]        PRDATA,
  input  logic [NUM_IRQ-1:0] IRQ_SRC,
  output logic               IRQ
);

  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] rise;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
    irq_sync_edge #(
      .IRQ_ACTIVE_HIGH(IRQ_ACTIVE_HIGH),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_sync (
      .clk  (PCLK),
      .rst_n(PRESETn),
      .src  (IRQ_SRC[g]),
      .level(s[g]),
      .rise (rise[g])
    );
  end

  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] en_q, en_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic               irq_q, irq_d;

  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] force_set;
  logic [NUM_IRQ-1:0] claim_clr;
  logic [NUM_IRQ-1:0] wdata;
  logic               wr_acc;
  logic               rd_acc;
  logic               claim_hit;
  reg_idx_e           reg_idx;

  logic [31:0]            pe_ext;
  logic                   claim_valid;
  logic [CLAIM_IDX_W-1:0] claim_idx;

  logic unused_pwdata;
  assign unused_pwdata = ^PWDATA[31:NUM_IRQ];

  assign reg_idx     = reg_idx_e'(PADDR);
  assign wr_acc      = PSEL & PENABLE & PWRITE;
  assign rd_acc      = PSEL & PENABLE & ~PWRITE;
  assign wdata       = PWDATA[NUM_IRQ-1:0];
  assign pe_ext      = 32'(pend_q & en_q);
  assign claim_valid = |pe_ext;
  assign claim_idx   = lowest_set(pe_ext);
  assign claim_hit   = rd_acc && (reg_idx == CLAIM) && claim_valid;

  always_comb begin
    w1c       = '0;
    force_set = '0;
    en_d      = en_q;
    mode_d    = mode_q;
    if (wr_acc) begin
      case (reg_idx)
        PEND:    w1c       = wdata;
        EN:      en_d      = wdata;
        MODE:    mode_d    = wdata;
        FORCE:   force_set = wdata;
        default: ;
      endcase
    end
  end

  // Claim clears only edge-mode sources; level sources re-derive from s anyway.
  always_comb begin
    claim_clr = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      claim_clr[i] = claim_hit && (claim_idx == CLAIM_IDX_W'(i)) && mode_q[i];
    end
  end

  // Set beats clear in edge mode so a rise coincident with W1C is not lost.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (mode_q[i]) begin
        if (rise[i] | force_set[i])      pend_d[i] = 1'b1;
        else if (w1c[i] | claim_clr[i])  pend_d[i] = 1'b0;
        else                             pend_d[i] = pend_q[i];
      end else begin
        pend_d[i] = s[i] | force_set[i];
      end
    end
  end

  always_comb begin
    irq_d = |(pend_q & en_q);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pend_q <= '0;
      en_q   <= '0;
      mode_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      en_q   <= en_d;
      mode_q <= mode_d;
      irq_q  <= irq_d;
    end
  end

  assign IRQ = irq_q;

  always_comb begin
    PRDATA = '0;
    if (PRESETn && PSEL && !PWRITE) begin
      case (reg_idx)
        RAW:   PRDATA = 32'(s);
        PEND:  PRDATA = 32'(pend_q);
        EN:    PRDATA = 32'(en_q);
        MODE:  PRDATA = 32'(mode_q);
        CLAIM: begin
          if (claim_valid) begin
            PRDATA[CLAIM_VALID_BIT]   = 1'b1;
            PRDATA[CLAIM_IDX_W-1:0]   = claim_idx;
          end
        end
        default: PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_irq_aggregator.sv
// Directed bench for apb_irq_aggregator: an active-high, 2-stage instance and
// an active-low, unsynchronized instance sharing one APB bus.
module tb_apb_irq_aggregator;

  logic        pclk;
  logic        presetn;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [2:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata_a, prdata_b, rdata;
  logic [7:0]  src_a, src_b;
  logic        irq_a, irq_b;
  logic        tgt;
  logic [31:0] d;

  int unsigned n_tests;
  int unsigned n_fail;

  apb_irq_aggregator #(.NUM_IRQ(8), .IRQ_ACTIVE_HIGH(1), .SYNC_STAGES(2)) dut_a (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel & ~tgt), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_a),
    .IRQ_SRC(src_a), .IRQ(irq_a)
  );

  apb_irq_aggregator #(.NUM_IRQ(8), .IRQ_ACTIVE_HIGH(0), .SYNC_STAGES(0)) dut_b (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel & tgt), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_b),
    .IRQ_SRC(src_b), .IRQ(irq_b)
  );

  assign rdata = tgt ? prdata_b : prdata_a;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [2:0] a, input logic [31:0] wd);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = wd;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [31:0] rd);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge pclk);
    penable = 1'b1;
    #1 rd = rdata;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  // Setup-phase-only look at PRDATA; no access edge, so no CLAIM side effect.
  task automatic peek(input logic [2:0] a, output logic [31:0] rd);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    #1 rd = rdata;
    psel = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; tgt = 1'b0;
    src_a = 8'hFF; src_b = 8'hFF;

    // 1: reset with sources asserted, then release with ENABLE=0
    repeat (3) @(negedge pclk);
    peek(3'd0, d); check("rst_raw", d, 32'h0);
    peek(3'd1, d); check("rst_pend", d, 32'h0);
    check("rst_irq", {31'b0, irq_a}, 32'h0);
    @(negedge pclk); presetn = 1'b1;
    @(negedge pclk);
    peek(3'd0, d); check("raw_sync1", d, 32'h0);
    @(negedge pclk);
    peek(3'd0, d); check("raw_sync2", d, 32'hFF);
    repeat (3) @(negedge pclk);
    check("irq_disabled", {31'b0, irq_a}, 32'h0);
    peek(3'd1, d); check("pend_disabled", d, 32'hFF);
    src_a = 8'h00;
    repeat (5) @(negedge pclk);
    peek(3'd1, d); check("pend_level_drop", d, 32'h0);

    // 2: edge mode bit 0, one-cycle pulse
    apb_write(3'd3, 32'h1);
    apb_write(3'd2, 32'h1);
    @(negedge pclk); src_a[0] = 1'b1;
    @(negedge pclk); src_a[0] = 1'b0;
    @(negedge pclk); check("e_irq_c2", {31'b0, irq_a}, 32'h0);
    @(negedge pclk); check("e_irq_c3", {31'b0, irq_a}, 32'h0);
    peek(3'd1, d); check("e_pend_c3", d, 32'h1);
    @(negedge pclk); check("e_irq_c4", {31'b0, irq_a}, 32'h1);
    apb_read(3'd4, d); check("e_claim", d, 32'h8000_0000);
    check("e_irq_after_claim", {31'b0, irq_a}, 32'h1);
    peek(3'd1, d); check("e_pend_cleared", d, 32'h0);
    @(negedge pclk); check("e_irq_low", {31'b0, irq_a}, 32'h0);

    // 3: level mode bit 3
    apb_write(3'd3, 32'h0);
    apb_write(3'd2, 32'h8);
    @(negedge pclk); src_a[3] = 1'b1;
    repeat (4) @(negedge pclk);
    check("l_irq_hi", {31'b0, irq_a}, 32'h1);
    apb_write(3'd1, 32'h8);
    apb_read(3'd1, d); check("l_w1c_ignored", d, 32'h8);
    check("l_irq_still", {31'b0, irq_a}, 32'h1);
    @(negedge pclk); src_a[3] = 1'b0;
    repeat (3) @(negedge pclk);
    peek(3'd1, d); check("l_pend_drop", d, 32'h0);
    @(negedge pclk); check("l_irq_drop", {31'b0, irq_a}, 32'h0);

    // 4: simultaneous edges on bits 2 and 5, claim ordering
    apb_write(3'd3, 32'h24);
    apb_write(3'd2, 32'h24);
    @(negedge pclk); src_a = 8'h24;
    repeat (4) @(negedge pclk);
    apb_read(3'd1, d); check("s_pend", d, 32'h24);
    check("s_irq", {31'b0, irq_a}, 32'h1);
    apb_read(3'd4, d); check("s_claim_2", d, 32'h8000_0002);
    apb_read(3'd4, d); check("s_claim_5", d, 32'h8000_0005);
    apb_read(3'd4, d); check("s_claim_none", d, 32'h0);
    apb_read(3'd1, d); check("s_pend_empty", d, 32'h0);
    check("s_irq_low", {31'b0, irq_a}, 32'h0);
    src_a = 8'h00;
    repeat (4) @(negedge pclk);
    @(negedge pclk); src_a[2] = 1'b1;
    apb_write(3'd1, 32'h4);
    apb_read(3'd1, d); check("s_set_beats_w1c", d, 32'h4);
    apb_write(3'd1, 32'h4);
    apb_read(3'd1, d); check("s_w1c_edge", d, 32'h0);
    src_a = 8'h00;
    repeat (4) @(negedge pclk);

    // 5: FORCE, write masking, reserved slots
    apb_write(3'd3, 32'h80);
    apb_write(3'd2, 32'h80);
    apb_write(3'd5, 32'h80);
    @(negedge pclk); check("f_irq", {31'b0, irq_a}, 32'h1);
    apb_read(3'd5, d); check("f_force_reads0", d, 32'h0);
    apb_read(3'd4, d); check("f_claim_7", d, 32'h8000_0007);
    peek(3'd1, d); check("f_pend_cleared", d, 32'h0);
    apb_write(3'd2, 32'hFFFF_FFFF);
    apb_read(3'd2, d); check("f_en_mask", d, 32'hFF);
    apb_write(3'd6, 32'hFFFF_FFFF);
    apb_read(3'd6, d); check("f_rsvd6", d, 32'h0);
    apb_read(3'd7, d); check("f_rsvd7", d, 32'h0);

    // 5b: active-low, unsynchronized instance with sources held at 1
    tgt = 1'b1;
    peek(3'd0, d); check("n_raw_idle", d, 32'h0);
    apb_write(3'd2, 32'hFF);
    repeat (2) @(negedge pclk);
    check("n_irq_idle", {31'b0, irq_b}, 32'h0);
    apb_read(3'd1, d); check("n_pend_idle", d, 32'h0);
    @(negedge pclk); src_b[1] = 1'b0;
    @(negedge pclk);
    peek(3'd1, d); check("n_pend_bit1", d, 32'h2);
    check("n_irq_c1", {31'b0, irq_b}, 32'h0);
    @(negedge pclk); check("n_irq_c2", {31'b0, irq_b}, 32'h1);
    peek(3'd0, d); check("n_raw_bit1", d, 32'h2);
    src_b = 8'hFF;
    tgt = 1'b0;

    // 6: asynchronous reset mid-operation
    apb_write(3'd3, 32'hFF);
    apb_write(3'd2, 32'hFF);
    apb_write(3'd5, 32'hFF);
    @(negedge pclk);
    check("r_irq_before", {31'b0, irq_a}, 32'h1);
    peek(3'd1, d); check("r_pend_before", d, 32'hFF);
    @(negedge pclk);
    #1 presetn = 1'b0;
    peek(3'd1, d); check("r_pend_async", d, 32'h0);
    check("r_irq_async", {31'b0, irq_a}, 32'h0);
    peek(3'd2, d); check("r_en_async", d, 32'h0);
    peek(3'd3, d); check("r_mode_async", d, 32'h0);
    @(negedge pclk); presetn = 1'b1;
    repeat (2) @(negedge pclk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
